fetch_redirect_ctrl: RTL and testbench

Sequencing controller for the fetch stage: selects the next PC, gates the IF/ID valid bit, and recovers from branch mispredictions. It keeps an in-order queue of the predicted next-PC for every fetched instruction and checks each entry against the actual outcome when that instruction leaves EX. On a mismatch it redirects the PC, flushes the younger stages, and issues a BTB write or invalidate. It sits between the BTB, the fetch datapath and the EX-stage branch unit.

---
 rtl/fetch_redirect_ctrl_pkg.sv | 24 ++
 rtl/fetch_redirect_ctrl_if.sv | 45 ++++
 rtl/fetch_pred_fifo.sv | 62 ++++++
 rtl/fetch_redirect_ctrl.sv | 127 ++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the fetch redirect controller: prediction-queue entry,
// FSM state encoding and the sequential next-PC helper.
package fetch_redirect_ctrl_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int PC_W     = 16;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pred_next;
    logic            pred_hit;
  } fq_entry_t;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // Fall-through address; wraps 0xFFFE -> 0x0000 naturally.
  function automatic logic [PC_W-1:0] pc_plus2(input logic [PC_W-1:0] pc);
    return pc + PC_W'(2);
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Bundle of BTB, fetch-datapath and EX branch-unit signals seen by the
// redirect controller. slave = controller, master = surrounding pipeline.
interface fetch_redirect_ctrl_if #(
  parameter int CNT_W = 16
);
  import fetch_redirect_ctrl_pkg::*;

  logic             i_stall;
  logic [PC_W-1:0]  i_fetch_pc;
  logic             i_pred_valid;
  logic [PC_W-1:0]  i_pred_target;
  logic             i_ex_valid;
  logic             i_ex_is_cf;
  logic             i_ex_taken;
  logic [PC_W-1:0]  i_ex_target;

  logic [PC_W-1:0]  o_pc_next;
  logic             o_pc_we;
  logic             o_if_id_valid;
  logic             o_flush;
  logic             o_btb_we;
  logic [PC_W-1:0]  o_btb_pc;
  logic [PC_W-1:0]  o_btb_target;
  logic             o_btb_set;
  logic [CNT_W-1:0] o_mispredicts;
  logic [CNT_W-1:0] o_branches;
  logic             o_underflow;

  modport master (
    output i_stall, i_fetch_pc, i_pred_valid, i_pred_target,
           i_ex_valid, i_ex_is_cf, i_ex_taken, i_ex_target,
    input  o_pc_next, o_pc_we, o_if_id_valid, o_flush,
           o_btb_we, o_btb_pc, o_btb_target, o_btb_set,
           o_mispredicts, o_branches, o_underflow
  );

  modport slave (
    input  i_stall, i_fetch_pc, i_pred_valid, i_pred_target,
           i_ex_valid, i_ex_is_cf, i_ex_taken, i_ex_target,
    output o_pc_next, o_pc_we, o_if_id_valid, o_flush,
           o_btb_we, o_btb_pc, o_btb_target, o_btb_set,
           o_mispredicts, o_branches, o_underflow
  );

endinterface

// File: rtl/fetch_pred_fifo.sv
// In-order prediction queue: circular buffer with wrap-bit pointers.
// clear wins over push and pop; push while full is only taken with a pop.
module fetch_pred_fifo
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  fq_entry_t push_data_i,
  input  logic      pop_i,
  input  logic      clear_i,
  output logic      full_o,
  output logic      empty_o,
  output fq_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  fq_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign do_push = push_i && (!full_o || do_pop) && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is pure data; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch sequencing: next-PC select, IF/ID valid gating, mispredict recovery
// against an in-order queue of predictions, BTB maintenance and counters.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_redirect_ctrl_if.slave bus
);

  fetch_state_t    state_q, state_d;
  fq_entry_t       head, push_entry;
  logic            q_full, q_empty;
  logic            pop_ok, push_ok, mispredict;
  logic [PC_W-1:0] pred_next, actual;

  logic             btb_we_q, btb_we_d;
  logic             btb_set_q, btb_set_d;
  logic [PC_W-1:0]  btb_pc_q, btb_pc_d;
  logic [PC_W-1:0]  btb_target_q, btb_target_d;
  logic [CNT_W-1:0] mispred_cnt_q, branch_cnt_q;
  logic             underflow_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign pred_next  = bus.i_pred_valid ? bus.i_pred_target : pc_plus2(bus.i_fetch_pc);
  assign push_entry = '{pc: bus.i_fetch_pc, pred_next: pred_next, pred_hit: bus.i_pred_valid};

  // Resolution of the oldest in-flight instruction
  assign pop_ok     = bus.i_ex_valid && !q_empty;
  assign actual     = (bus.i_ex_is_cf && bus.i_ex_taken) ? bus.i_ex_target : pc_plus2(head.pc);
  assign mispredict = pop_ok && (actual != head.pred_next);

  fetch_pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_ok),
    .push_data_i (push_entry),
    .pop_i       (pop_ok),
    .clear_i     (mispredict),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .head_o      (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Redirect outputs; a mispredict overrides stall and queue-full
  always_comb begin
    push_ok           = (state_q == RUN) && !bus.i_stall &&
                        (!q_full || pop_ok) && !mispredict;
    bus.o_flush       = mispredict;
    bus.o_pc_we       = mispredict || push_ok;
    bus.o_pc_next     = '0;
    if (mispredict)   bus.o_pc_next = actual;
    else if (push_ok) bus.o_pc_next = pred_next;
    bus.o_if_id_valid = (state_q == RUN) && bus.o_pc_we && !bus.o_flush;
  end

  always_comb begin
    btb_we_d     = 1'b0;
    btb_set_d    = btb_set_q;
    btb_pc_d     = btb_pc_q;
    btb_target_d = btb_target_q;
    if (pop_ok && bus.i_ex_is_cf) begin
      if (bus.i_ex_taken && mispredict) begin
        btb_we_d     = 1'b1;
        btb_set_d    = 1'b1;
        btb_pc_d     = head.pc;
        btb_target_d = bus.i_ex_target;
      end else if (!bus.i_ex_taken && head.pred_hit) begin
        btb_we_d     = 1'b1;
        btb_set_d    = 1'b0;
        btb_pc_d     = head.pc;
        btb_target_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btb_we_q      <= 1'b0;
      btb_set_q     <= 1'b0;
      btb_pc_q      <= '0;
      btb_target_q  <= '0;
      mispred_cnt_q <= '0;
      branch_cnt_q  <= '0;
      underflow_q   <= 1'b0;
    end else begin
      btb_we_q     <= btb_we_d;
      btb_set_q    <= btb_set_d;
      btb_pc_q     <= btb_pc_d;
      btb_target_q <= btb_target_d;
      if (mispredict)                mispred_cnt_q <= sat_inc(mispred_cnt_q);
      if (pop_ok && bus.i_ex_is_cf)  branch_cnt_q  <= sat_inc(branch_cnt_q);
      if (bus.i_ex_valid && q_empty) underflow_q   <= 1'b1;
    end
  end

  assign bus.o_btb_we      = btb_we_q;
  assign bus.o_btb_set     = btb_set_q;
  assign bus.o_btb_pc      = btb_pc_q;
  assign bus.o_btb_target  = btb_target_q;
  assign bus.o_mispredicts = mispred_cnt_q;
  assign bus.o_branches    = branch_cnt_q;
  assign bus.o_underflow   = underflow_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: each scenario task drives one
// feature and checks combinational outputs at negedge, registered ones after posedge.
module tb_fetch_redirect_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fetch_redirect_ctrl_if #(.CNT_W(16)) bus ();

  fetch_redirect_ctrl #(
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic stall, input logic [15:0] fpc,
                        input logic pv, input logic [15:0] pt,
                        input logic exv, input logic cf, input logic tk,
                        input logic [15:0] ext);
    bus.i_stall       = stall;
    bus.i_fetch_pc    = fpc;
    bus.i_pred_valid  = pv;
    bus.i_pred_target = pt;
    bus.i_ex_valid    = exv;
    bus.i_ex_is_cf    = cf;
    bus.i_ex_taken    = tk;
    bus.i_ex_target   = ext;
  endtask

  task automatic idle();
    set_in(1'b1, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1'b0, 16'h1234, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.o_pc_we !== 1'b0) begin failures++; $display("FAIL rst_pc_we got=%b exp=0", bus.o_pc_we); end
    checks++; if (bus.o_pc_next !== 16'h0) begin failures++; $display("FAIL rst_pc_next got=%h exp=0000", bus.o_pc_next); end
    checks++; if (bus.o_flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", bus.o_flush); end
    checks++; if (bus.o_btb_we !== 1'b0 || bus.o_btb_pc !== 16'h0) begin failures++; $display("FAIL rst_btb got=%b/%h exp=0/0000", bus.o_btb_we, bus.o_btb_pc); end
    checks++; if (bus.o_branches !== 16'h0 || bus.o_mispredicts !== 16'h0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", bus.o_branches, bus.o_mispredicts); end
    checks++; if (bus.o_underflow !== 1'b0) begin failures++; $display("FAIL rst_underflow got=%b exp=0", bus.o_underflow); end
    step();
    reset = 1'b0;
    set_in(1'b0, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.o_pc_we !== 1'b0 || bus.o_if_id_valid !== 1'b0) begin failures++; $display("FAIL boot_gate got=%b/%b exp=0/0", bus.o_pc_we, bus.o_if_id_valid); end
    step();
  endtask

  task automatic test_seq_fetch();
    logic [15:0] pc;
    for (int i = 0; i < 4; i++) begin
      pc = 16'(2 * i);
      set_in(1'b0, pc, 1'b0, 16'h0, (i != 0), 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      checks++; if (bus.o_pc_next !== pc + 16'd2 || bus.o_pc_we !== 1'b1) begin failures++; $display("FAIL seq_pc%0d got=%h/%b exp=%h/1", i, bus.o_pc_next, bus.o_pc_we, pc + 16'd2); end
      checks++; if (bus.o_flush !== 1'b0 || bus.o_if_id_valid !== 1'b1) begin failures++; $display("FAIL seq_flush%0d got=%b/%b exp=0/1", i, bus.o_flush, bus.o_if_id_valid); end
      step();
    end
    set_in(1'b1, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.o_pc_we !== 1'b0 || bus.o_flush !== 1'b0) begin failures++; $display("FAIL seq_drain got=%b/%b exp=0/0", bus.o_pc_we, bus.o_flush); end
    step();
    idle();
    checks++; if (bus.o_branches !== 16'd0) begin failures++; $display("FAIL seq_branches got=%0d exp=0", bus.o_branches); end
  endtask

  task automatic test_btb_hit();
    set_in(1'b0, 16'h0010, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.o_pc_next !== 16'h0040) begin failures++; $display("FAIL hit_pc_next got=%h exp=0040", bus.o_pc_next); end
    step();
    set_in(1'b1, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0040);
    @(negedge clk);
    checks++; if (bus.o_flush !== 1'b0 || bus.o_pc_we !== 1'b0) begin failures++; $display("FAIL hit_no_flush got=%b/%b exp=0/0", bus.o_flush, bus.o_pc_we); end
    step();
    idle();
    checks++; if (bus.o_branches !== 16'd1 || bus.o_mispredicts !== 16'd0) begin failures++; $display("FAIL hit_counters got=%0d/%0d exp=1/0", bus.o_branches, bus.o_mispredicts); end
    checks++; if (bus.o_btb_we !== 1'b0) begin failures++; $display("FAIL hit_btb_we got=%b exp=0", bus.o_btb_we); end
    step();
  endtask

  task automatic test_mispredict_taken();
    set_in(1'b0, 16'h0020, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.o_pc_next !== 16'h0022) begin failures++; $display("FAIL mt_pc1 got=%h exp=0022", bus.o_pc_next); end
    step();
    set_in(1'b0, 16'h0022, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    step();
    set_in(1'b0, 16'h0024, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0100);
    @(negedge clk);
    checks++; if (bus.o_flush !== 1'b1 || bus.o_pc_next !== 16'h0100 || bus.o_pc_we !== 1'b1) begin failures++; $display("FAIL mt_redirect got=%b/%h/%b exp=1/0100/1", bus.o_flush, bus.o_pc_next, bus.o_pc_we); end
    checks++; if (bus.o_if_id_valid !== 1'b0) begin failures++; $display("FAIL mt_if_id got=%b exp=0", bus.o_if_id_valid); end
    step();
    idle();
    checks++; if (bus.o_btb_we !== 1'b1 || bus.o_btb_set !== 1'b1) begin failures++; $display("FAIL mt_btb_we got=%b/%b exp=1/1", bus.o_btb_we, bus.o_btb_set); end
    checks++; if (bus.o_btb_pc !== 16'h0020 || bus.o_btb_target !== 16'h0100) begin failures++; $display("FAIL mt_btb_data got=%h/%h exp=0020/0100", bus.o_btb_pc, bus.o_btb_target); end
    checks++; if (bus.o_mispredicts !== 16'd1 || bus.o_branches !== 16'd2) begin failures++; $display("FAIL mt_counters got=%0d/%0d exp=1/2", bus.o_mispredicts, bus.o_branches); end
    step();
    checks++; if (bus.o_btb_we !== 1'b0) begin failures++; $display("FAIL mt_btb_pulse got=%b exp=0", bus.o_btb_we); end
  endtask

  task automatic test_mispredict_not_taken();
    set_in(1'b0, 16'h0030, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.o_pc_next !== 16'h0080) begin failures++; $display("FAIL mn_pc1 got=%h exp=0080", bus.o_pc_next); end
    step();
    set_in(1'b1, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0080);
    @(negedge clk);
    checks++; if (bus.o_flush !== 1'b1 || bus.o_pc_next !== 16'h0032 || bus.o_pc_we !== 1'b1) begin failures++; $display("FAIL mn_redirect got=%b/%h/%b exp=1/0032/1", bus.o_flush, bus.o_pc_next, bus.o_pc_we); end
    step();
    idle();
    checks++; if (bus.o_btb_we !== 1'b1 || bus.o_btb_set !== 1'b0 || bus.o_btb_pc !== 16'h0030) begin failures++; $display("FAIL mn_btb_inval got=%b/%b/%h exp=1/0/0030", bus.o_btb_we, bus.o_btb_set, bus.o_btb_pc); end
    checks++; if (bus.o_mispredicts !== 16'd2 || bus.o_branches !== 16'd3) begin failures++; $display("FAIL mn_counters got=%0d/%0d exp=2/3", bus.o_mispredicts, bus.o_branches); end
    step();
  endtask

  task automatic test_full();
    logic [15:0] pc;
    for (int i = 0; i < 5; i++) begin
      pc = 16'h0200 + 16'(2 * i);
      set_in(1'b0, pc, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      if (i < 4) begin
        checks++; if (bus.o_pc_we !== 1'b1 || bus.o_pc_next !== pc + 16'd2) begin failures++; $display("FAIL full_push%0d got=%b/%h exp=1/%h", i, bus.o_pc_we, bus.o_pc_next, pc + 16'd2); end
      end else begin
        checks++; if (bus.o_pc_we !== 1'b0 || bus.o_if_id_valid !== 1'b0) begin failures++; $display("FAIL full_stall got=%b/%b exp=0/0", bus.o_pc_we, bus.o_if_id_valid); end
      end
      step();
    end
    set_in(1'b0, 16'h0208, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.o_pc_we !== 1'b1 || bus.o_pc_next !== 16'h020A || bus.o_flush !== 1'b0) begin failures++; $display("FAIL full_pop_push got=%b/%h/%b exp=1/020a/0", bus.o_pc_we, bus.o_pc_next, bus.o_flush); end
    step();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      checks++; if (bus.o_flush !== 1'b0) begin failures++; $display("FAIL full_drain%0d got=%b exp=0", i, bus.o_flush); end
      step();
    end
    idle();
    checks++; if (bus.o_underflow !== 1'b0) begin failures++; $display("FAIL full_underflow got=%b exp=0", bus.o_underflow); end
  endtask

  task automatic test_wrap();
    set_in(1'b0, 16'hFFFE, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.o_pc_next !== 16'h0000 || bus.o_pc_we !== 1'b1) begin failures++; $display("FAIL wrap_pc got=%h/%b exp=0000/1", bus.o_pc_next, bus.o_pc_we); end
    step();
    set_in(1'b1, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.o_flush !== 1'b0) begin failures++; $display("FAIL wrap_pop got=%b exp=0", bus.o_flush); end
    step();
    idle();
  endtask

  task automatic test_underflow();
    set_in(1'b1, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.o_underflow !== 1'b0 || bus.o_flush !== 1'b0) begin failures++; $display("FAIL uf_before got=%b/%b exp=0/0", bus.o_underflow, bus.o_flush); end
    step();
    idle();
    checks++; if (bus.o_underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%b exp=1", bus.o_underflow); end
    step();
    checks++; if (bus.o_underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%b exp=1", bus.o_underflow); end
  endtask

  task automatic test_reset_mid();
    set_in(1'b0, 16'h0300, 1'b1, 16'h0302, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.o_pc_next !== 16'h0302) begin failures++; $display("FAIL rm_pc1 got=%h exp=0302", bus.o_pc_next); end
    step();
    set_in(1'b0, 16'h0302, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.o_flush !== 1'b0 || bus.o_pc_next !== 16'h0304) begin failures++; $display("FAIL rm_pc2 got=%b/%h exp=0/0304", bus.o_flush, bus.o_pc_next); end
    step();
    checks++; if (bus.o_btb_we !== 1'b1 || bus.o_btb_set !== 1'b0 || bus.o_btb_pc !== 16'h0300) begin failures++; $display("FAIL rm_pending got=%b/%b/%h exp=1/0/0300", bus.o_btb_we, bus.o_btb_set, bus.o_btb_pc); end
    reset = 1'b1;
    set_in(1'b0, 16'h0304, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    #1;
    checks++; if (bus.o_btb_we !== 1'b0 || bus.o_btb_pc !== 16'h0) begin failures++; $display("FAIL rm_btb_discard got=%b/%h exp=0/0000", bus.o_btb_we, bus.o_btb_pc); end
    checks++; if (bus.o_branches !== 16'd0 || bus.o_mispredicts !== 16'd0 || bus.o_underflow !== 1'b0) begin failures++; $display("FAIL rm_clear got=%0d/%0d/%b exp=0/0/0", bus.o_branches, bus.o_mispredicts, bus.o_underflow); end
    step();
    step();
    reset = 1'b0;
    set_in(1'b0, 16'h0400, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.o_pc_we !== 1'b0) begin failures++; $display("FAIL rm_boot got=%b exp=0", bus.o_pc_we); end
    step();
    set_in(1'b1, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    step();
    idle();
    checks++; if (bus.o_underflow !== 1'b1) begin failures++; $display("FAIL rm_queue_empty got=%b exp=1", bus.o_underflow); end
    checks++; if (bus.o_btb_we !== 1'b0) begin failures++; $display("FAIL rm_no_write got=%b exp=0", bus.o_btb_we); end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle();
    step();
    test_reset();
    test_seq_fetch();
    test_btb_hit();
    test_mispredict_taken();
    test_mispredict_not_taken();
    test_full();
    test_wrap();
    test_underflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
